// File: rtl/tx_serial_pkg.sv
// Shared definitions for the serial transmit path: state encodings of the
// request arbiter and of the transmitter control unit, plus default timeout.
package tx_serial_pkg;

   localparam int TIMEOUT_PADRAO = 8192;

   typedef enum logic [3:0] {
      OCIOSO  = 4'd0,
      PARTIDA = 4'd1,
      ESPERA  = 4'd2,
      FINAL   = 4'd3,
      ERRO    = 4'd4
   } estado_t;

   typedef enum logic [3:0] {
      UC_INICIAL     = 4'd0,
      UC_PREPARA     = 4'd1,
      UC_TRANSMITE   = 4'd2,
      UC_ESPERA_TICK = 4'd3,
      UC_FINAL       = 4'd4
   } uc_estado_t;

endpackage

// File: rtl/tx_serial_arbitro_if.sv
// Bundle between the requesters/transmitter side and the arbiter.
interface tx_serial_arbitro_if #(
   parameter int N_REQ = 4
);

   logic [N_REQ-1:0]   req;
   logic [7*N_REQ-1:0] dados;
   logic [N_REQ-1:0]   ack;
   logic               tx_partida;
   logic [6:0]         tx_dados;
   logic               tx_pronto;
   logic               ocupado;
   logic               erro;
   logic [3:0]         db_estado;

   modport master (
      output req, dados, tx_pronto,
      input  ack, tx_partida, tx_dados, ocupado, erro, db_estado
   );

   modport slave (
      input  req, dados, tx_pronto,
      output ack, tx_partida, tx_dados, ocupado, erro, db_estado
   );

endinterface

// File: rtl/arbitro_rr.sv
// Combinational round-robin selector: lowest requesting index at or above
// ptr, otherwise the lowest requesting index overall.
module arbitro_rr #(
   parameter int N_REQ = 4,
   parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [PW-1:0]    grant,
   output logic             valid
);

   int unsigned p;
   logic        achou;

   // Two passes: first from ptr upward, then wrap to the bottom.
   always_comb begin
      grant = '0;
      achou = 1'b0;
      p     = 32'(ptr);
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!achou && req[i] && (i >= p)) begin
            grant = PW'(i);
            achou = 1'b1;
         end
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!achou && req[i]) begin
            grant = PW'(i);
            achou = 1'b1;
         end
      end
      valid = achou;
   end

endmodule

// File: rtl/tx_serial_arbitro.sv
// Arbitrates N_REQ requesters onto one 7O1 serial transmitter, with a
// saturating wait counter that aborts a transfer if pronto never arrives.
module tx_serial_arbitro
   import tx_serial_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = TIMEOUT_PADRAO
) (
   input  logic               clock,
   input  logic               reset,
   tx_serial_arbitro_if.slave bus
);

   localparam int            PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int            CW      = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_FIM = CW'(TIMEOUT - 1);

   estado_t          estado, prox_estado;
   logic [PW-1:0]    ptr, vencedor, grant, ptr_seguinte;
   logic             valid;
   logic [CW-1:0]    contador;
   logic [6:0]       dados_lat;
   logic [N_REQ-1:0] ack_c;
   logic             partida_c, erro_c;

   arbitro_rr #(.N_REQ(N_REQ), .PW(PW)) u_rr (
      .req   (bus.req),
      .ptr   (ptr),
      .grant (grant),
      .valid (valid)
   );

   assign ptr_seguinte = (vencedor == PW'(N_REQ - 1)) ? '0 : vencedor + 1'b1;

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) estado <= OCIOSO;
      else        estado <= prox_estado;
   end

   // Next state and per-state pulses.
   always_comb begin
      prox_estado = estado;
      ack_c       = '0;
      partida_c   = 1'b0;
      erro_c      = 1'b0;
      unique case (estado)
         OCIOSO: begin
            if (valid) begin
               ack_c[grant] = 1'b1;
               prox_estado  = PARTIDA;
            end
         end
         PARTIDA: begin
            partida_c   = 1'b1;
            prox_estado = ESPERA;
         end
         ESPERA: begin
            // pronto takes priority over an expiry in the same cycle
            if (bus.tx_pronto)            prox_estado = FINAL;
            else if (contador == CNT_FIM) prox_estado = ERRO;
         end
         FINAL:   prox_estado = OCIOSO;
         ERRO: begin
            erro_c      = 1'b1;
            prox_estado = OCIOSO;
         end
         default: prox_estado = OCIOSO;
      endcase
   end

   // Winner/payload latch, wait counter and round-robin pointer.
   always_ff @(posedge clock) begin
      if (!reset) begin
         ptr       <= '0;
         vencedor  <= '0;
         contador  <= '0;
         dados_lat <= '0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (valid) begin
                  vencedor  <= grant;
                  dados_lat <= bus.dados[7*int'(grant) +: 7];
               end
            end
            PARTIDA: contador <= '0;
            ESPERA: begin
               if (contador != '1) contador <= contador + 1'b1;
            end
            FINAL, ERRO: ptr <= ptr_seguinte;
            default: ;
         endcase
      end
   end

   // Pulses are held low while reset is asserted, even mid-transfer.
   assign bus.ack        = reset ? ack_c : '0;
   assign bus.tx_partida = reset & partida_c;
   assign bus.erro       = reset & erro_c;
   assign bus.ocupado    = reset & (estado != OCIOSO);
   assign bus.tx_dados   = dados_lat;
   assign bus.db_estado  = estado;

endmodule

// File: tb/tb_tx_serial_arbitro.sv
// Directed plus randomized bench for tx_serial_arbitro. dut_a uses a short
// timeout; dut_b keeps the default one for long transmitter stubs.
module tb_tx_serial_arbitro;

   localparam int N    = 4;
   localparam int TO_A = 16;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req_t = '0;
   logic [27:0] dados_t = '0;
   logic        tx_pronto_t = 1'b0;

   int errors = 0;
   int checks = 0;
   int ptr_m  = 0;
   int got;

   always #5 clock = ~clock;

   tx_serial_arbitro_if #(.N_REQ(N)) if_a ();
   tx_serial_arbitro_if #(.N_REQ(N)) if_b ();

   assign if_a.req = req_t;  assign if_a.dados = dados_t;  assign if_a.tx_pronto = tx_pronto_t;
   assign if_b.req = req_t;  assign if_b.dados = dados_t;  assign if_b.tx_pronto = tx_pronto_t;

   tx_serial_arbitro #(.N_REQ(N), .TIMEOUT(TO_A)) dut_a (.clock(clock), .reset(reset), .bus(if_a));
   tx_serial_arbitro #(.N_REQ(N))                 dut_b (.clock(clock), .reset(reset), .bus(if_b));

   function automatic int g_ack(input bit s);  return s ? int'(if_b.ack)        : int'(if_a.ack);        endfunction
   function automatic int g_par(input bit s);  return s ? int'(if_b.tx_partida) : int'(if_a.tx_partida); endfunction
   function automatic int g_dad(input bit s);  return s ? int'(if_b.tx_dados)   : int'(if_a.tx_dados);   endfunction
   function automatic int g_ocu(input bit s);  return s ? int'(if_b.ocupado)    : int'(if_a.ocupado);    endfunction
   function automatic int g_err(input bit s);  return s ? int'(if_b.erro)       : int'(if_a.erro);       endfunction
   function automatic int g_db(input bit s);   return s ? int'(if_b.db_estado)  : int'(if_a.db_estado);  endfunction

   // Reference: scan the N indices in rotated order starting at p.
   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0; req_t = '0; tx_pronto_t = 1'b0;
      tick; tick;
      reset = 1'b1;
      ptr_m = 0;
   endtask

   // One full transfer; pronto arrives 'delay' cycles after tx_partida.
   task automatic do_xfer(input bit s, input logic [3:0] rv, input logic [27:0] dv,
                          input int delay, input bit hold, input bit noise, output int w);
      logic [6:0] ed;
      req_t = rv; dados_t = dv; tx_pronto_t = 1'b0;
      #1;
      w  = rr_pick(rv, ptr_m);
      ed = dv[7*w +: 7];
      chk("ack_grant", g_ack(s), 1 << w);
      chk("db_idle", g_db(s), 0);
      tick;
      if (!hold) req_t = '0;
      #1;
      chk("partida", g_par(s), 1);
      chk("db_partida", g_db(s), 1);
      chk("tx_dados", g_dad(s), int'(ed));
      chk("ack_off", g_ack(s), 0);
      for (int c = 1; c <= delay; c++) begin
         tick;
         if (noise && !hold) begin
            req_t   = 4'($urandom);
            dados_t = 28'($urandom);
         end
         tx_pronto_t = (c == delay);
         #1;
         chk("db_espera", g_db(s), 2);
         chk("partida_once", g_par(s), 0);
         chk("ack_espera", g_ack(s), 0);
         chk("erro_espera", g_err(s), 0);
         chk("dados_stable", g_dad(s), int'(ed));
      end
      tick;
      tx_pronto_t = 1'($urandom);
      req_t = hold ? rv : '0;
      #1;
      chk("db_final", g_db(s), 3);
      chk("erro_final", g_err(s), 0);
      chk("ocupado_final", g_ocu(s), 1);
      tick;
      tx_pronto_t = 1'b0;
      #1;
      ptr_m = (w + 1) % N;
      chk("db_back_idle", g_db(s), 0);
      if (!hold) begin
         chk("ocupado_idle", g_ocu(s), 0);
         chk("ack_idle", g_ack(s), 0);
      end
   endtask

   initial begin
      int w;
      // reset holds every pulse low even with all requests pending
      reset = 1'b0; req_t = 4'hF;
      tick; tick;
      chk("rst_ack", g_ack(0), 0);
      chk("rst_partida", g_par(0), 0);
      chk("rst_ocupado", g_ocu(0), 0);
      chk("rst_erro", g_err(0), 0);
      chk("rst_db", g_db(0), 0);
      chk("rst_dados", g_dad(0), 0);
      reset = 1'b1; req_t = '0;
      #1;
      chk("idle_ack", g_ack(0), 0);
      chk("idle_ocupado", g_ocu(0), 0);
      ptr_m = 0;

      // single request
      do_xfer(0, 4'b0001, 28'h41, 3, 0, 0, got);
      chk("single_grant", got, 0);

      // pronto in the same cycle as expiry
      do_xfer(0, 4'b0100, 28'h0AB_CDEF, TO_A, 0, 0, got);
      chk("race_grant", got, 2);

      // wrap with ptr=3
      do_reset;
      do_xfer(0, 4'b0100, 28'h123_4567, 2, 0, 0, got);
      chk("wrap_setup", got, 2);
      do_xfer(0, 4'b0101, 28'h765_4321, 2, 0, 0, got);
      chk("wrap_g0", got, 0);
      do_xfer(0, 4'b0101, 28'h765_4321, 2, 0, 0, got);
      chk("wrap_g1", got, 2);
      do_xfer(0, 4'b0101, 28'h765_4321, 2, 0, 0, got);
      chk("wrap_g2", got, 0);

      // timeout on dut_a
      req_t = 4'b0010; #1;
      w = rr_pick(4'b0010, ptr_m);
      chk("to_ack", g_ack(0), 1 << w);
      tick; req_t = '0; #1;
      chk("to_partida", g_par(0), 1);
      for (int c = 1; c <= TO_A; c++) begin
         tick; #1;
         chk("to_wait_erro", g_err(0), 0);
         chk("to_wait_db", g_db(0), 2);
      end
      tick; #1;
      chk("to_erro", g_err(0), 1);
      chk("to_db_erro", g_db(0), 4);
      tick; #1;
      chk("to_erro_once", g_err(0), 0);
      chk("to_db_idle", g_db(0), 0);
      ptr_m = (w + 1) % N;
      do_xfer(0, 4'hF, 28'h0FF_00FF, 2, 0, 0, got);
      chk("to_ptr_adv", got, 2);

      // reset in ESPERA, pronto alongside and afterwards
      req_t = 4'b0010; #1;
      chk("re_ack", g_ack(0), 1 << rr_pick(4'b0010, ptr_m));
      tick; req_t = '0; tick; tick;
      reset = 1'b0; tx_pronto_t = 1'b1; #1;
      chk("re_ocupado", g_ocu(0), 0);
      chk("re_erro", g_err(0), 0);
      chk("re_partida", g_par(0), 0);
      tick; reset = 1'b1; #1;
      chk("re_db", g_db(0), 0);
      chk("re_erro2", g_err(0), 0);
      tick; #1;
      chk("re_pronto_ignored", g_db(0), 0);
      chk("re_no_partida", g_par(0), 0);
      tx_pronto_t = 1'b0;
      ptr_m = 0;
      do_xfer(0, 4'hF, 28'h555_5555, 2, 0, 0, got);
      chk("re_ptr0", got, 0);

      // fairness on dut_b with a 20-cycle transmitter
      do_reset;
      for (int k = 0; k < 8; k++) begin
         do_xfer(1, 4'hF, 28'h0A1_B2C3, 20, 1, 0, got);
         chk("fair_order", got, k % N);
      end

      // randomized transfers on dut_a
      do_reset;
      for (int k = 0; k < 25; k++) begin
         do_xfer(0, 4'($urandom_range(1, 15)), 28'($urandom), int'($urandom_range(1, TO_A)),
                 1'($urandom), 1'b1, got);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tx_serial_arbitro.md
TX_SERIAL_ARBITRO -- requirements
Module: tx_serial_arbitro

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one 7O1 serial transmitter.
REQ-002 Parameter TIMEOUT, default 8192: maximum clock cycles spent waiting for transmitter pronto.
REQ-003 clock  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req  input  N_REQ  level request per requester; held until its ack.
REQ-006 dados  input  7*N_REQ  ASCII payload per requester; requester i owns bits [7*i+6:7*i].
REQ-007 ack  output  N_REQ  one-cycle pulse; the winner's payload is latched this cycle.
REQ-008 tx_partida  output  1  one-cycle start pulse to the transmitter.
REQ-009 tx_dados  output  7  latched payload to the transmitter; stable from PARTIDA until return to OCIOSO.
REQ-010 tx_pronto  input  1  transmitter end-of-frame pulse.
REQ-011 ocupado  output  1  high in every state except OCIOSO.
REQ-012 erro  output  1  one-cycle pulse when TIMEOUT expires.
REQ-013 db_estado  output  4  current state encoding, for debug.

Function
REQ-014 The FSM SHALL have exactly these states: OCIOSO=0, PARTIDA=1, ESPERA=2, FINAL=3, ERRO=4.
REQ-015 OCIOSO with req==0 SHALL stay in OCIOSO with all outputs low.
REQ-016 OCIOSO with any req set SHALL, in that same cycle, select the winner by round-robin starting at pointer ptr.
REQ-017 On selection, the SHALL pulse ack[winner], latch dados of the winner into tx_dados, latch the winner index, and go to PARTIDA.
REQ-018 PARTIDA SHALL assert tx_partida for exactly one cycle, clear the timeout counter, and go to ESPERA.
REQ-019 ESPERA SHALL increment the timeout counter every cycle.
REQ-020 ESPERA with tx_pronto=1 SHALL go to FINAL.
REQ-021 ESPERA with counter==TIMEOUT-1 and tx_pronto=0 SHALL go to ERRO.
REQ-022 If tx_pronto and timeout expiry occur in the same cycle, tx_pronto SHALL win and the FSM SHALL go to FINAL.
REQ-023 tx_pronto seen in OCIOSO, PARTIDA, FINAL or ERRO SHALL be ignored.
REQ-024 FINAL SHALL set ptr = winner+1, wrapping N_REQ-1 to 0, and go to OCIOSO.
REQ-025 ERRO SHALL pulse erro for one cycle, advance ptr exactly as FINAL does, and go to OCIOSO.
REQ-026 Round-robin SHALL pick the lowest index i >= ptr with req[i]=1; if there is none, it SHALL pick the lowest index i < ptr.
REQ-027 A requester dropping req before ack SHALL simply not be granted; there is no error.
REQ-028 req changes outside OCIOSO SHALL not affect the transfer in progress.
REQ-029 Transfer latency SHALL be: ack cycle 0, tx_partida cycle 1, return to OCIOSO 2 cycles after the tx_pronto cycle.
REQ-030 With req held continuously, the next grant SHALL occur in the first OCIOSO cycle after FINAL.
REQ-031 The timeout counter SHALL be clog2(TIMEOUT)+1 bits wide and SHALL saturate, never wrap.
REQ-032 db_estado SHALL equal the state encoding of REQ-014.

Reset
REQ-033 reset=0 at a rising edge SHALL force OCIOSO, ptr=0, winner=0, counter=0, tx_dados=0.
REQ-034 During and after reset, ack, tx_partida, ocupado and erro SHALL all be 0.
REQ-035 Reset mid-transfer SHALL abort with no ack, tx_partida or erro pulse, regardless of tx_pronto.

Structure
REQ-036 State encodings and the default TIMEOUT SHALL live in a shared package, tx_serial_pkg, alongside the tx_serial_uc state constants.
REQ-037 The round-robin selector SHALL be one combinational sub-module, arbitro_rr, with inputs req and ptr and outputs grant index and valid.
REQ-038 The FSM, latches and counter SHALL remain in tx_serial_arbitro, within an RTL budget of about 150-250 lines.

Verification
REQ-039 Single request: req=0001, dados[6:0]=0x41 -> ack=0001 at cycle 0, tx_partida at cycle 1, tx_dados=0x41; after tx_pronto, OCIOSO within 2 cycles.
REQ-040 Fairness: req=1111 held for 8 transfers with a tx_pronto stub of 20 cycles -> grant order 0,1,2,3,0,1,2,3.
REQ-041 Wrap: ptr=3, req=0101 -> grant 0, then 2, then 0.
REQ-042 Timeout: TIMEOUT=16, tx_pronto never asserted -> erro pulse at cycle 17 after tx_partida, then OCIOSO, ptr advanced.
REQ-043 Race: tx_pronto asserted in the same cycle as timeout expiry -> FINAL, erro stays 0.
REQ-044 Reset in ESPERA: reset=0 for one cycle -> OCIOSO, ptr=0, no pulses; a later tx_pronto is ignored.
